// File: rtl/reg_op_pkg.sv
// Shared types and constants for the register-operation sequencer:
// opcode encoding, FSM states and instruction field positions.
package reg_op_pkg;

    localparam int DATA_W     = 16;
    localparam int MUL_CYCLES = 16;
    localparam int IMM_W      = 8;

    localparam int OPC_LSB = 13;
    localparam int RD_LSB  = 11;
    localparam int RS1_LSB = 9;
    localparam int RS2_LSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100,
        OP_LI  = 3'b101,
        OP_SLT = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_MUL,
        S_WB
    } state_e;

    function automatic opcode_e instr_opcode(input logic [15:0] i);
        return opcode_e'(i[OPC_LSB +: 3]);
    endfunction

    function automatic logic [1:0] instr_field2(input logic [15:0] i, input int lsb);
        return i[lsb +: 2];
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Signed shift-add multiplier: multiplies operand magnitudes over MUL_CYCLES
// iterations and applies the sign at the end, giving the low DATA_W product bits.
module seq_multiplier
    import reg_op_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] a_abs, b_abs;

    assign a_abs = a[DATA_W-1] ? -a : a;
    assign b_abs = b[DATA_W-1] ? -b : b;

    // The first iteration happens on the load edge so the product is ready
    // in the last of the MUL_CYCLES cycles the sequencer spends waiting.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;
        if (start) begin
            acc_d    = b_abs[0] ? a_abs : '0;
            mcand_d  = a_abs << 1;
            mplier_d = b_abs >> 1;
            neg_d    = a[DATA_W-1] ^ b[DATA_W-1];
            count_d  = CNT_W'(1);
        end else if (count_q == CNT_W'(MUL_CYCLES)) begin
            count_d = '0;
        end else if (count_q != '0) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
        end
    end

    assign done    = (count_q == CNT_W'(MUL_CYCLES));
    assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/reg_op_sequencer.sv
// Register-file requester: accepts one instruction, reads its operands,
// executes it (iterative multiply for MUL) and issues a single write-back.
module reg_op_sequencer
    import reg_op_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [1:0]        read_reg_index1,
    output logic [1:0]        read_reg_index2,
    input  logic [DATA_W-1:0] reg_read_1,
    input  logic [DATA_W-1:0] reg_read_2,
    output logic              write_enable,
    output logic [1:0]        write_reg_index,
    output logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic              busy
);

    state_e            state_q, state_d;
    opcode_e           op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [1:0]        ridx1_q, ridx1_d, ridx2_q, ridx2_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic              we_q, we_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;
    logic [1:0]        wri_q, wri_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] alu_result;
    logic              mul_start, mul_done;
    logic [DATA_W-1:0] mul_product;

    assign mul_start = (state_q == S_EXEC) && (op_q == OP_MUL);

    seq_multiplier u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (opa_q),
        .b       (opb_q),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        case (op_q)
            OP_ADD:  alu_result = opa_q + opb_q;
            OP_SUB:  alu_result = opa_q - opb_q;
            OP_AND:  alu_result = opa_q & opb_q;
            OP_OR:   alu_result = opa_q | opb_q;
            OP_LI:   alu_result = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(opa_q) < $signed(opb_q)};
            default: alu_result = '0;
        endcase
    end

    // NOTE: every *_d starts as its *_q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ridx1_d = ridx1_q;
        ridx2_d = ridx2_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        wri_d   = wri_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: if (instr_valid && ready_q) begin
                op_d    = instr_opcode(instr);
                rd_d    = instr_field2(instr, RD_LSB);
                imm_d   = instr[IMM_LSB +: IMM_W];
                ridx1_d = instr_field2(instr, RS1_LSB);
                ridx2_d = instr_field2(instr, RS2_LSB);
                state_d = S_READ;
            end
            S_READ: begin
                opa_d   = reg_read_1;
                opb_d   = reg_read_2;
                state_d = S_EXEC;
            end
            S_EXEC: if (op_q == OP_MUL) begin
                state_d = S_MUL;
            end else begin
                we_d    = (op_q != OP_NOP);
                done_d  = 1'b1;
                wri_d   = rd_q;
                wd_d    = alu_result;
                state_d = S_WB;
            end
            S_MUL: if (mul_done) begin
                we_d    = 1'b1;
                done_d  = 1'b1;
                wri_d   = rd_q;
                wd_d    = mul_product;
                state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            rd_q    <= '0;
            imm_q   <= '0;
            ridx1_q <= '0;
            ridx2_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            wri_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ridx1_q <= ridx1_d;
            ridx2_q <= ridx2_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            wri_q   <= wri_d;
            wd_q    <= wd_d;
        end
    end

    assign instr_ready     = ready_q;
    assign busy            = busy_q;
    assign read_reg_index1 = ridx1_q;
    assign read_reg_index2 = ridx2_q;
    assign write_enable    = we_q;
    assign write_reg_index = wri_q;
    assign write_data      = wd_q;
    assign done            = done_q;

endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Multi-cycle instruction sequencer that acts as the requesting side of the processor register file. It accepts one 16-bit instruction at a time over a valid/ready handshake, drives the two register-file read indices, and captures the returned operands. It then executes the operation, including a 16-cycle iterative multiply, and issues exactly one write-back through the register-file write port. It sits between instruction fetch/decode and the register file.

## Interface
- DATA_W, 16, operand/result width (signed two's complement)
- MUL_CYCLES, 16, iterations of the shift-add multiplier (equals DATA_W)

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present on instr
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  16  [15:13] opcode, [12:11] rd, [10:9] rs1, [8:7] rs2, [7:0] imm8 (LI only)
- read_reg_index1  out  2  register-file read index 1 (rs1)
- read_reg_index2  out  2  register-file read index 2 (rs2)
- reg_read_1  in  16  signed operand A returned by the register file
- reg_read_2  in  16  signed operand B returned by the register file
- write_enable  out  1  one-cycle write strobe to the register file
- write_reg_index  out  2  destination index (rd)
- write_data  out  16  signed result
- done  out  1  one-cycle pulse when an instruction retires, including NOP
- busy  out  1  high in every state except IDLE

## Operation
- Opcodes:
  - 000 ADD: rs1+rs2
  - 001 SUB: rs1−rs2
  - 010 AND
  - 011 OR
  - 100 MUL: low 16 bits of the signed product
  - 101 LI: sign-extend imm8
  - 110 SLT: 1 if rs1<rs2 signed, else 0
  - 111 NOP: no write
- Arithmetic wraps modulo 2^16. There is no overflow flag.
- States: IDLE, READ, EXEC, MUL, WB.
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr and go to READ.
  - READ: drive read indices from the latched rs1/rs2. At the end of the cycle, capture reg_read_1/2, which the register file updates on the intervening falling edge. Go to EXEC.
  - EXEC: if opcode=MUL, load the multiplier and go to MUL. Otherwise compute the result into a register and go to WB.
  - MUL: run exactly MUL_CYCLES cycles, then go to WB with the product.
  - WB: write_enable=1 (0 for NOP), write_reg_index=rd, write_data=result, done=1. Go to IDLE.
- write_enable is never high outside WB.
- Read indices hold their last value outside READ.
- instr_valid while busy is ignored. instr_ready=0, and the instruction is not latched.
- rd equal to rs1 or rs2 is legal. Operands are already captured before write-back.
- Back-to-back instructions are hazard-free. WB writes on the rising edge ending WB, and the next READ is at least two cycles later.
- Reset mid-operation (any state): next state IDLE, multiplier cleared, no write issued, no done pulse.

## Timing
- Reset values: instr_ready=1 (IDLE), busy=0, write_enable=0, done=0, write_reg_index=0, write_data=0, read_reg_index1/2=0.
- Non-MUL latency: accept edge → READ (cycle 1) → EXEC (cycle 2) → WB (cycle 3). write_enable/done are high in the 3rd cycle after acceptance.
- MUL latency: READ, EXEC, 16×MUL, WB. write_enable is high in the 19th cycle after acceptance.
- Throughput: one non-MUL instruction per 4 cycles (WB→IDLE→accept).
- All outputs are registered.

## Structure
- Package reg_op_pkg: DATA_W; opcode constants OP_ADD…OP_NOP; state enum; instr field bit positions.
- One sub-module, seq_multiplier:
  - Signed shift-add multiplier with start/done.
  - Operands are the absolute values, with the sign applied at the end.
  - Produces the low 16 bits of the product in MUL_CYCLES cycles.

## Test plan
- Reset, then LI r1,#0x7F → one write_enable in the 3rd cycle after accept, with index 1 and data 0x007F; done pulses once. Then LI r2,#0x80 → data 0xFF80.
- r1=0x7FFF, r2=0x0001: ADD r3,r1,r2 → write 0x8000 (wrap). SUB r0,r2,r1 → 0x8002. SLT r0,r1,r2 → 0.
- r1=−3 (0xFFFD), r2=7: MUL r3,r1,r2 → write_data 0xFFEB exactly 19 cycles after accept. instr_ready=0 for the whole operation.
- Hold instr_valid high during a MUL with a different ADD on instr → that ADD is accepted only in the IDLE cycle after WB. No earlier write occurs.
- NOP → done pulses in cycle 3 with write_enable=0 throughout.
- Assert reset during cycle 8 of a MUL → IDLE next cycle, no write_enable, no done. A subsequent ADD executes correctly.
